imem_access_arbiter: RTL and testbench

Single-port instruction-memory access controller for the LC3 environment. It shares one imem port between two requesters: the fetch path (reads) and a program loader (writes). It sequences each access through a fixed-latency memory read pipeline and returns fetched instructions to the fetch requester. It sits between the fetch stage / loader and the instruction memory model driven by the imem interface.

---
 rtl/imem_access_arbiter.sv | 122 ++++++++++++
 tb/tb_imem_access_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/imem_access_arbiter.sv
// Shares a single instruction-memory port between the fetch path (reads) and the
// program loader (writes), with a bounded loader streak so fetch cannot starve.
module imem_access_arbiter #(
  parameter int unsigned ADDR_W           = 16,
  parameter int unsigned DATA_W           = 16,
  parameter int unsigned MEM_LATENCY      = 1,
  parameter int unsigned LOADER_BURST_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("imem_access_arbiter: MEM_LATENCY must be in 1..4");
  end
  if (LOADER_BURST_MAX < 1 || LOADER_BURST_MAX > 15) begin : g_bad_burst
    $error("imem_access_arbiter: LOADER_BURST_MAX must be in 1..15");
  end

  localparam logic [3:0] STREAK_MAX = 4'(LOADER_BURST_MAX);
  localparam logic [1:0] LAT_LAST   = 2'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_RD,
    RD_WAIT,
    ISSUE_WR
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] ld_streak;
  logic [1:0] lat_cnt;
  logic       fetch_win;

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Grants are suppressed during reset so nothing is accepted that the flops then drop.
  always_comb begin
    state_nxt = state;
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    fetch_win = fetch_req && (!ld_req || (ld_streak == STREAK_MAX));
    unique case (state)
      IDLE: begin
        if (!reset) begin
          if (fetch_win) begin
            fetch_gnt = 1'b1;
            state_nxt = ISSUE_RD;
          end else if (ld_req) begin
            ld_gnt    = 1'b1;
            state_nxt = ISSUE_WR;
          end
        end
      end
      ISSUE_RD: state_nxt = RD_WAIT;
      RD_WAIT:  if (lat_cnt == '0) state_nxt = IDLE;
      ISSUE_WR: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      fetch_rvalid <= 1'b0;
      fetch_rdata  <= '0;
      lat_cnt      <= '0;
      ld_streak    <= '0;
    end else begin
      mem_en       <= fetch_gnt | ld_gnt;
      mem_we       <= ld_gnt;
      fetch_rvalid <= 1'b0;
      if (fetch_gnt)   mem_addr <= fetch_addr;
      else if (ld_gnt) mem_addr <= ld_addr;
      if (ld_gnt) mem_wdata <= ld_wdata;

      if (state == ISSUE_RD) begin
        lat_cnt <= LAT_LAST;
      end else if (state == RD_WAIT) begin
        if (lat_cnt == '0) begin
          fetch_rvalid <= 1'b1;
          fetch_rdata  <= mem_rdata;
        end else begin
          lat_cnt <= lat_cnt - 2'd1;
        end
      end

      // Streak only counts loader wins that actually kept a fetch waiting.
      if (fetch_gnt)
        ld_streak <= '0;
      else if (ld_gnt && fetch_req && (ld_streak != STREAK_MAX))
        ld_streak <= ld_streak + 4'd1;
      else if ((state == IDLE) && !fetch_req)
        ld_streak <= '0;
    end
  end

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Randomized bench for imem_access_arbiter: a timestamped transaction model predicts
// grants, memory strobes and returned data cycle by cycle.
module tb_imem_access_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LAT    = 3;
  localparam int unsigned BMAX   = 3;
  localparam int          NCYC   = 3000;

  logic              clock = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  imem_access_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MEM_LATENCY(LAT),
    .LOADER_BURST_MAX(BMAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .fetch_req(fetch_req),
    .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata(fetch_rdata),
    .ld_req(ld_req),
    .ld_addr(ld_addr),
    .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Model: cycles of remaining occupancy plus timestamps of the pending issue,
  // capture and return events.
  int                busy_left;
  int                streak;
  int                iss_cyc, cap_cyc, rv_cyc;
  logic              iss_we;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_wdata;
  logic [DATA_W-1:0] cap_val;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata, e_rdata;
  logic              e_fg, e_lg, e_idle;
  logic              f_g, l_g;
  int                pct;

  initial begin
    reset = 1'b1; fetch_req = 1'b0; ld_req = 1'b0;
    fetch_addr = '0; ld_addr = '0; ld_wdata = '0; mem_rdata = '0;
    busy_left = 0; streak = 0; iss_cyc = -1; cap_cyc = -1; rv_cyc = -1;
    iss_we = 1'b0; iss_addr = '0; iss_wdata = '0; cap_val = '0;
    e_addr = '0; e_wdata = '0; e_rdata = '0;
    f_g = 1'b0; l_g = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clock);
      #1;
      cyc = c;
      pct = (c < 1000) ? 95 : (c < 2000) ? 40 : 80;
      reset = (c < 2) || ($urandom_range(0, 149) == 0);
      mem_rdata = DATA_W'($urandom);
      if (fetch_req && !f_g) begin
        if ($urandom_range(0, 40) == 0) fetch_req = 1'b0;
      end else begin
        fetch_req  = ($urandom_range(0, 99) < pct);
        fetch_addr = ADDR_W'($urandom);
      end
      if (ld_req && !l_g) begin
        if ($urandom_range(0, 40) == 0) ld_req = 1'b0;
      end else begin
        ld_req   = ($urandom_range(0, 99) < pct);
        ld_addr  = ADDR_W'($urandom);
        ld_wdata = DATA_W'($urandom);
      end

      @(negedge clock);
      e_idle = (busy_left == 0);
      e_fg   = e_idle && !reset && fetch_req && (!ld_req || streak == int'(BMAX));
      e_lg   = e_idle && !reset && ld_req && !e_fg;
      if (c == iss_cyc) begin
        e_addr = iss_addr;
        if (iss_we) e_wdata = iss_wdata;
      end
      if (c == rv_cyc) e_rdata = cap_val;

      if (c >= 1) begin
        check("fetch_gnt", 32'(fetch_gnt), 32'(e_fg));
        check("ld_gnt", 32'(ld_gnt), 32'(e_lg));
        check("busy", 32'(busy), 32'(!e_idle));
        check("mem_en", 32'(mem_en), 32'(c == iss_cyc));
        check("mem_we", 32'(mem_we), 32'((c == iss_cyc) && iss_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
        check("fetch_rvalid", 32'(fetch_rvalid), 32'(c == rv_cyc));
        check("fetch_rdata", 32'(fetch_rdata), 32'(e_rdata));
      end
      f_g = fetch_gnt;
      l_g = ld_gnt;

      if (reset) begin
        busy_left = 0; streak = 0; iss_cyc = -1; cap_cyc = -1; rv_cyc = -1;
        e_addr = '0; e_wdata = '0; e_rdata = '0;
      end else begin
        if (c == cap_cyc) cap_val = mem_rdata;
        if (busy_left > 0) busy_left--;
        if (e_fg) begin
          busy_left = int'(LAT) + 1;
          iss_cyc = c + 1; iss_we = 1'b0; iss_addr = fetch_addr;
          cap_cyc = c + 1 + int'(LAT);
          rv_cyc  = c + 2 + int'(LAT);
          streak  = 0;
        end else if (e_lg) begin
          busy_left = 1;
          iss_cyc = c + 1; iss_we = 1'b1; iss_addr = ld_addr; iss_wdata = ld_wdata;
          streak = fetch_req ? ((streak < int'(BMAX)) ? streak + 1 : streak) : 0;
        end else if (e_idle && !fetch_req) begin
          streak = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
